// File: rtl/load_store_unit.sv
// Load/store unit: one bus transaction per request, size/sign handling, misalign/illegal/timeout faults.
// Latency: done 2 cycles after a zero-wait request; busy stalls the pipeline until the bus acks or times out.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

    state_t            state, state_next;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [2:0]        lat_funct3;
    logic              lat_we;
    logic              fault_mis;
    logic [CNT_W-1:0]  wait_cnt;

    logic              request;
    logic              f3_legal;
    logic              addr_mis;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_ext;
    logic [31:0]       st_data;
    logic [3:0]        st_strb;

    assign request = memory_read | memory_write;

    // Unsigned sizes exist only for loads; a write with funct3 100/101 is illegal.
    always_comb begin
        f3_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = ~memory_write;
            default:                f3_legal = 1'b0;
        endcase
        addr_mis = ((funct3[1:0] == 2'b01) && address[0]) ||
                   ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
    end

    always_comb begin
        ld_byte = bus_rdata[7:0];
        case (lat_addr[1:0])
            2'b00: ld_byte = bus_rdata[7:0];
            2'b01: ld_byte = bus_rdata[15:8];
            2'b10: ld_byte = bus_rdata[23:16];
            2'b11: ld_byte = bus_rdata[31:24];
            default: ld_byte = bus_rdata[7:0];
        endcase
        ld_half = lat_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lat_funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    always_comb begin
        case (lat_funct3[1:0])
            2'b00: begin
                st_data = {4{lat_wdata[7:0]}};
                st_strb = 4'b0001 << lat_addr[1:0];
            end
            2'b01: begin
                st_data = {2{lat_wdata[15:0]}};
                st_strb = lat_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = lat_wdata;
                st_strb = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        done         = 1'b0;
        misaligned   = 1'b0;
        access_fault = 1'b0;
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_addr     = 32'd0;
        bus_wdata    = 32'd0;
        bus_wstrb    = 4'b0000;
        case (state)
            IDLE: begin
                busy = request & ~reset;
                if (request)
                    state_next = (!f3_legal || addr_mis) ? FAULT : ACCESS;
            end
            ACCESS: begin
                busy     = ~reset;
                bus_req  = 1'b1;
                bus_we   = lat_we;
                bus_addr = {lat_addr[31:2], 2'b00};
                if (lat_we) begin
                    bus_wdata = st_data;
                    bus_wstrb = st_strb;
                end
                if (bus_ack)                    state_next = DONE;
                else if (wait_cnt == CNT_LAST)  state_next = FAULT;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            FAULT: begin
                done         = 1'b1;
                misaligned   = fault_mis;
                access_fault = ~fault_mis;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_funct3 <= 3'd0;
            lat_we     <= 1'b0;
            fault_mis  <= 1'b0;
            wait_cnt   <= '0;
            read_data  <= 32'd0;
        end else begin
            if (state == IDLE && request) begin
                lat_addr   <= address;
                lat_wdata  <= write_data;
                lat_funct3 <= funct3;
                lat_we     <= memory_write;
                // Zero here also marks a later timeout as an access fault.
                fault_mis  <= f3_legal & addr_mis;
            end
            if (state == ACCESS) begin
                if (!bus_ack) wait_cnt <= wait_cnt + 1'b1;
                if (bus_ack && !lat_we) read_data <= ld_ext;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memory_read = 1'b0;
    logic        memory_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        busy, done, misaligned, access_fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .memory_read(memory_read), .memory_write(memory_write),
        .funct3(funct3), .address(address), .write_data(write_data),
        .read_data(read_data), .busy(busy), .done(done),
        .misaligned(misaligned), .access_fault(access_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        af;
        int          done_cyc;
        int          req_cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ack_delay = 0;
    bit   no_ack    = 1'b0;
    bit   stray_ack = 1'b0;
    int   rcnt      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus slave model: acks after ack_delay wait cycles; stray_ack drives ack while idle.
    always @(posedge clk) begin
        #2;
        if (bus_req) begin
            bus_ack = !no_ack && (rcnt == ack_delay);
            rcnt++;
        end else begin
            rcnt    = 0;
            bus_ack = stray_ack;
        end
    end

    // Monitor: pops scoreboard entries on bus activity and on done.
    bus_t cur_bus;
    bit   prev_req = 1'b0;
    int   req_cnt  = 0;
    always @(negedge clk) begin
        if (reset) begin
            req_cnt  = 0;
            prev_req = 1'b0;
        end else begin
            if (bus_req) begin
                if (!prev_req) begin
                    if (bus_q.size() == 0) chk("unexpected_bus_req", 32'd1, 32'd0);
                    else cur_bus = bus_q.pop_front();
                end
                chk("bus_we",    {31'd0, bus_we}, {31'd0, cur_bus.we});
                chk("bus_addr",  bus_addr,        cur_bus.addr);
                chk("bus_wdata", bus_wdata,       cur_bus.wdata);
                chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, cur_bus.strb});
                req_cnt++;
            end
            prev_req = bus_req;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("read_data",    read_data, e.rd);
                    chk("misaligned",   {31'd0, misaligned},   {31'd0, e.mis});
                    chk("access_fault", {31'd0, access_fault}, {31'd0, e.af});
                    chk("done_cycle",   cyc,     e.done_cyc);
                    chk("req_cycles",   req_cnt, e.req_cyc);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                end
                req_cnt = 0;
            end
        end
    end

    task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int dly, input bit noack, input logic [31:0] rdat,
                         input bit exp_bus, input logic [31:0] exp_baddr,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                         input logic [31:0] exp_rd, input bit exp_mis, input bit exp_af,
                         input bit expect_done);
        exp_t e;
        bus_t b;
        int   n;
        int   req;
        @(posedge clk); #1;
        memory_read  = mr;
        memory_write = mw;
        funct3       = f3;
        address      = a;
        write_data   = wd;
        ack_delay    = dly;
        no_ack       = noack;
        bus_rdata    = rdat;
        n   = cyc;
        req = exp_bus ? (noack ? TMO : dly + 1) : 0;
        if (exp_bus) begin
            b.we = mw; b.addr = exp_baddr; b.wdata = exp_wdata; b.strb = exp_strb;
            bus_q.push_back(b);
        end
        if (expect_done) begin
            e.rd = exp_rd; e.mis = exp_mis; e.af = exp_af;
            e.done_cyc = n + 1 + req; e.req_cyc = req;
            exp_q.push_back(e);
        end
        #1 chk("busy_request_cycle", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        memory_read  = 1'b0;
        memory_write = 1'b0;
        chk("busy_next_cycle", {31'd0, busy}, {31'd0, exp_bus});
        if (expect_done) repeat (req + 2) @(posedge clk);
    endtask

    initial begin
        #1 reset = 1'b1;
        memory_read = 1'b1;
        #2;
        chk("rst_busy",       {31'd0, busy},         32'd0);
        chk("rst_done",       {31'd0, done},         32'd0);
        chk("rst_bus_req",    {31'd0, bus_req},      32'd0);
        chk("rst_bus_we",     {31'd0, bus_we},       32'd0);
        chk("rst_wstrb",      {28'd0, bus_wstrb},    32'd0);
        chk("rst_bus_addr",   bus_addr,              32'd0);
        chk("rst_bus_wdata",  bus_wdata,             32'd0);
        chk("rst_read_data",  read_data,             32'd0);
        chk("rst_faults",     {30'd0, misaligned, access_fault}, 32'd0);
        memory_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        //     mr mw f3      addr          wdata         dly noack rdata         bus baddr         bwdata        strb     exp_rd        mis af done
        issue(1, 0, 3'b000, 32'h0000_0103, 32'h0,        0, 0, 32'h8011_2233, 1, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80, 0, 0, 1);

        @(posedge clk); #1 stray_ack = 1'b1;
        repeat (3) @(posedge clk); #1 stray_ack = 1'b0;
        chk("stray_ack_read_data", read_data, 32'hFFFF_FF80);

        issue(0, 1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 0, 0, 32'h0,        1, 32'h0000_0200, 32'hBEEF_BEEF, 4'b1100, 32'hFFFF_FF80, 0, 0, 1);
        issue(1, 0, 3'b010, 32'h0000_0101, 32'h0,        0, 0, 32'h0,         0, 32'h0,         32'h0,        4'b0000, 32'hFFFF_FF80, 1, 0, 1);
        issue(1, 0, 3'b101, 32'h0000_0002, 32'h0,        3, 0, 32'h8001_0000, 1, 32'h0000_0000, 32'h0,        4'b0000, 32'h0000_8001, 0, 0, 1);
        issue(1, 0, 3'b010, 32'h0000_0100, 32'h0,        0, 1, 32'h0,         1, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_8001, 0, 1, 1);
        issue(0, 1, 3'b000, 32'h0000_0101, 32'h1234_56AB, 0, 0, 32'h0,        1, 32'h0000_0100, 32'hABAB_ABAB, 4'b0010, 32'h0000_8001, 0, 0, 1);
        issue(1, 0, 3'b001, 32'h0000_0006, 32'h0,        1, 0, 32'h9ABC_1234, 1, 32'h0000_0004, 32'h0,        4'b0000, 32'hFFFF_9ABC, 0, 0, 1);
        issue(1, 0, 3'b100, 32'h0000_0201, 32'h0,        0, 0, 32'h1234_F0AA, 1, 32'h0000_0200, 32'h0,        4'b0000, 32'h0000_00F0, 0, 0, 1);
        issue(1, 0, 3'b011, 32'h0000_0000, 32'h0,        0, 0, 32'h0,         0, 32'h0,         32'h0,        4'b0000, 32'h0000_00F0, 0, 1, 1);
        issue(0, 1, 3'b001, 32'h0000_0203, 32'h0000_1111, 0, 0, 32'h0,        0, 32'h0,         32'h0,        4'b0000, 32'h0000_00F0, 1, 0, 1);
        issue(1, 1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 0, 0, 32'h0,        1, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 32'h0000_00F0, 0, 0, 1);
        issue(1, 0, 3'b010, 32'h0000_0300, 32'h0,        0, 0, 32'hDEAD_BEEF, 1, 32'h0000_0300, 32'h0,        4'b0000, 32'hDEAD_BEEF, 0, 0, 1);
        issue(1, 0, 3'b000, 32'h0000_0104, 32'h0,        2, 0, 32'h0000_007F, 1, 32'h0000_0104, 32'h0,        4'b0000, 32'h0000_007F, 0, 0, 1);
        issue(0, 1, 3'b100, 32'h0000_0010, 32'h0000_0055, 0, 0, 32'h0,        0, 32'h0,         32'h0,        4'b0000, 32'h0000_007F, 0, 1, 1);

        // Abort a load mid-ACCESS with reset; no done may follow.
        issue(1, 0, 3'b010, 32'h0000_0500, 32'h0,        0, 1, 32'h0,         1, 32'h0000_0500, 32'h0,        4'b0000, 32'h0,        0, 0, 0);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("mid_rst_bus_req",   {31'd0, bus_req}, 32'd0);
        chk("mid_rst_busy",      {31'd0, busy},    32'd0);
        chk("mid_rst_done",      {31'd0, done},    32'd0);
        chk("mid_rst_read_data", read_data,        32'd0);
        @(posedge clk); #1 reset = 1'b0;

        issue(0, 1, 3'b010, 32'h0000_0080, 32'h1122_3344, 0, 0, 32'h0,        1, 32'h0000_0080, 32'h1122_3344, 4'b1111, 32'h0,        0, 0, 1);
        issue(1, 0, 3'b010, 32'h0000_0084, 32'h0,        0, 0, 32'h5566_7788, 1, 32'h0000_0084, 32'h0,        4'b0000, 32'h5566_7788, 0, 0, 1);

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("bus_queue_drained",  bus_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
